fpu_fmt_to_fp80_pipe: RTL and testbench

Pipelined, handshaked converter from IEEE single (FP32) or double (FP64) precision to 8087 80-bit extended precision, with the format selected per transaction. It sits between the FPU memory-operand fetch path and the FP80 register stack. It supersedes the single-format, enable-pulsed FP64 converter. It adds FP32 support, valid/ready backpressure, a transaction tag, exact denormal normalisation, signalling-NaN quieting, and 8087 exception flags (I, D).

---
 rtl/fpu_fmt_to_fp80_pipe.sv | 188 ++++++++++++++++++
 tb/tb_fpu_fmt_to_fp80_pipe.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_fmt_to_fp80_pipe.sv
// fpu_fmt_to_fp80_pipe: two-stage valid/ready converter from FP32/FP64 to
// 8087 80-bit extended precision. S1 unpacks and classifies the operand and
// counts leading zeros of the fraction. S2 rebiases, normalises and packs
// the result and raises the I/D flags. The S2 registers are the output port.
module fpu_fmt_to_fp80_pipe #(
    parameter int unsigned TAG_W      = 4,
    parameter bit          QUIET_SNAN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_fmt,
    input  logic [63:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [79:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       out_flags
);

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_DENORM,
        CLS_NORMAL,
        CLS_INF,
        CLS_QNAN,
        CLS_SNAN,
        CLS_RSVD
    } cls_t;

    // Unpacked operand (combinational, from the input port)
    logic        u_sign;
    logic [10:0] u_exp;
    logic [51:0] u_frac;
    logic        u_fp32;
    logic        u_exp_max;
    cls_t        u_cls;
    logic [5:0]  u_lz;

    // S1 registers
    logic             s1_valid;
    logic             s1_sign;
    logic [10:0]      s1_exp;
    logic [51:0]      s1_frac;
    logic             s1_fp32;
    cls_t             s1_cls;
    logic [5:0]       s1_lz;
    logic [TAG_W-1:0] s1_tag;

    // S2 packing results (combinational, from S1)
    logic        p_sign;
    logic [14:0] p_exp;
    logic [63:0] p_mant;
    logic [1:0]  p_flags;
    logic [14:0] p_bias;

    logic s2_adv;
    logic s1_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Unpack and classify; the FP32 fraction is left-aligned into the 52-bit
    // field so both formats share one leading-zero count and one packer.
    always_comb begin
        u_fp32 = (in_fmt == 2'b00);
        if (u_fp32) begin
            u_sign    = in_data[31];
            u_exp     = {3'b000, in_data[30:23]};
            u_frac    = {in_data[22:0], 29'b0};
            u_exp_max = &in_data[30:23];
        end else begin
            u_sign    = in_data[63];
            u_exp     = in_data[62:52];
            u_frac    = in_data[51:0];
            u_exp_max = &in_data[62:52];
        end

        if (in_fmt[1]) begin
            u_cls = CLS_RSVD;
        end else if (u_exp == '0) begin
            u_cls = (u_frac == '0) ? CLS_ZERO : CLS_DENORM;
        end else if (u_exp_max) begin
            if (u_frac == '0)   u_cls = CLS_INF;
            else if (u_frac[51]) u_cls = CLS_QNAN;
            else                 u_cls = CLS_SNAN;
        end else begin
            u_cls = CLS_NORMAL;
        end

        // Highest set bit wins since the scan runs upward.
        u_lz = '0;
        for (int unsigned i = 0; i < 52; i++) begin
            if (u_frac[i]) u_lz = 6'(51 - i);
        end
    end

    // S1 register stage: captures the unpacked operand when S1 can advance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_frac  <= '0;
            s1_fp32  <= 1'b0;
            s1_cls   <= CLS_ZERO;
            s1_lz    <= '0;
            s1_tag   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= u_sign;
                s1_exp  <= u_exp;
                s1_frac <= u_frac;
                s1_fp32 <= u_fp32;
                s1_cls  <= u_cls;
                s1_lz   <= u_lz;
                s1_tag  <= in_tag;
            end
        end
    end

    // Rebias, normalise and pack. A denormal's leading one sits lz places
    // below the aligned fraction MSB, so the exponent is the normal bias
    // minus lz and the fraction shifts up by lz+1 to reach bit 63.
    always_comb begin
        p_bias  = s1_fp32 ? 15'd16256 : 15'd15360;
        p_sign  = s1_sign;
        p_exp   = '0;
        p_mant  = '0;
        p_flags = 2'b00;
        case (s1_cls)
            CLS_ZERO: begin
                p_exp  = '0;
                p_mant = '0;
            end
            CLS_DENORM: begin
                p_exp   = p_bias - {9'b0, s1_lz};
                p_mant  = {1'b0, s1_frac, 11'b0} << ({1'b0, s1_lz} + 7'd1);
                p_flags = 2'b01;
            end
            CLS_NORMAL: begin
                p_exp  = {4'b0, s1_exp} + p_bias;
                p_mant = {1'b1, s1_frac, 11'b0};
            end
            CLS_INF: begin
                p_exp  = '1;
                p_mant = 64'h8000_0000_0000_0000;
            end
            CLS_QNAN: begin
                p_exp  = '1;
                p_mant = {1'b1, s1_frac, 11'b0};
            end
            CLS_SNAN: begin
                p_exp   = '1;
                p_mant  = {1'b1, (s1_frac[51] | QUIET_SNAN), s1_frac[50:0], 11'b0};
                p_flags = 2'b10;
            end
            default: begin
                p_sign  = 1'b1;
                p_exp   = '1;
                p_mant  = 64'hC000_0000_0000_0000;
                p_flags = 2'b10;
            end
        endcase
    end

    // S2/output register stage: holds the result stable while stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_flags <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data  <= {p_sign, p_exp, p_mant};
                out_tag   <= s1_tag;
                out_flags <= p_flags;
            end
        end
    end

endmodule

// File: tb/tb_fpu_fmt_to_fp80_pipe.sv
// Self-checking bench for fpu_fmt_to_fp80_pipe: a negedge monitor pops a
// scoreboard of expected {flags, data, tag} on every output transfer.
module tb_fpu_fmt_to_fp80_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_fmt;
    logic [63:0] in_data;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [79:0] out_data;
    logic [3:0]  out_tag;
    logic [1:0]  out_flags;

    int checks = 0;
    int errors = 0;

    logic [81:0] drv_exp;
    logic [85:0] sb[$];
    logic        prev_stall;
    logic [85:0] prev_out;
    logic        exp_rdy;
    logic [85:0] e;

    fpu_fmt_to_fp80_pipe #(.TAG_W(4), .QUIET_SNAN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    // Reference: value-based conversion, normalising denormals bit by bit.
    function automatic logic [81:0] ref_conv(input logic [1:0] fmt, input logic [63:0] d);
        logic s;
        int ex, ev, emax, bias;
        logic [63:0] m;
        logic [1:0] fl;
        if (fmt[1]) return {2'b10, 80'hFFFF_C000_0000_0000_0000};
        if (fmt == 2'b00) begin
            s = d[31]; ev = int'(d[30:23]); emax = 255; bias = 127;
            m = {1'b0, d[22:0], 40'b0};
        end else begin
            s = d[63]; ev = int'(d[62:52]); emax = 2047; bias = 1023;
            m = {1'b0, d[51:0], 11'b0};
        end
        fl = 2'b00;
        if (ev == 0) begin
            if (m == 64'd0) ex = 0;
            else begin
                ex = 1 - bias + 16383;
                fl = 2'b01;
                while (!m[63]) begin m = m << 1; ex = ex - 1; end
            end
        end else if (ev == emax) begin
            ex = 32767;
            if (m != 64'd0 && !m[62]) begin fl = 2'b10; m[62] = 1'b1; end
            m[63] = 1'b1;
        end else begin
            ex = ev - bias + 16383;
            m[63] = 1'b1;
        end
        return {fl, s, 15'(ex), m};
    endfunction

    // Scoreboard monitor: in_ready rule, stall stability, in-order results
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            checks++;
            exp_rdy = !(sb.size() == 2 && !out_ready);
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL in_ready: got %b want %b (occupancy %0d)", in_ready, exp_rdy, sb.size());
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || {out_flags, out_data, out_tag} !== prev_out) begin
                    errors++;
                    $display("FAIL stall_stable: got v=%b %h want v=1 %h", out_valid,
                             {out_flags, out_data, out_tag}, prev_out);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL extra_output: got %h with empty scoreboard", out_data);
                end else begin
                    e = sb.pop_front();
                    if ({out_flags, out_data, out_tag} !== e) begin
                        errors++;
                        $display("FAIL result: got flags=%b data=%h tag=%h want flags=%b data=%h tag=%h",
                                 out_flags, out_data, out_tag, e[85:84], e[83:4], e[3:0]);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_flags, out_data, out_tag};
            if (in_valid && in_ready) sb.push_back({drv_exp, in_tag});
        end
    end

    task automatic send(input logic [1:0] f, input logic [63:0] d, input logic [3:0] t,
                        input logic [81:0] x, output int tries);
        logic acc;
        drv_exp = x; in_fmt = f; in_data = d; in_tag = t; in_valid = 1'b1;
        tries = 0;
        while (1) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            tries++;
            if (acc) break;
            if (tries >= 50) begin
                checks++; errors++;
                $display("FAIL send_timeout: got no accept in %0d cycles want accept", tries);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic gen(output logic [1:0] f, output logic [63:0] d);
        int k;
        d = {$urandom, $urandom};
        k = int'($urandom_range(0, 7));
        f = (k < 3) ? 2'b00 : (k < 6) ? 2'b01 : 2'(k - 4);
        k = int'($urandom_range(0, 4));
        if (f == 2'b00) begin
            if (k == 1) d[30:23] = 8'h00;
            if (k == 2) d[30:23] = 8'hFF;
            if (k == 3) d[30:0]  = '0;
        end else begin
            if (k == 1) d[62:52] = 11'h000;
            if (k == 2) d[62:52] = 11'h7FF;
            if (k == 3) d[62:0]  = '0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_fmt = '0; in_data = '0; in_tag = '0; out_ready = 1'b1;
        drv_exp = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_data, out_tag, out_flags} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h t=%h f=%b want all zero",
                     out_valid, out_data, out_tag, out_flags);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int t;
        send(2'b00, 64'h0000_0000_3F80_0000, 4'h1, {2'b00, 80'h3FFF_8000_0000_0000_0000}, t);
        send(2'b01, 64'h3FF0_0000_0000_0000, 4'h2, {2'b00, 80'h3FFF_8000_0000_0000_0000}, t);
        wait_drain();
    endtask

    task automatic test_denormals();
        int t;
        send(2'b00, 64'hDEAD_BEEF_0000_0001, 4'h3, {2'b01, 80'h3F6A_8000_0000_0000_0000}, t);
        send(2'b01, 64'h0000_0000_0000_0001, 4'h4, {2'b01, 80'h3BCD_8000_0000_0000_0000}, t);
        wait_drain();
    endtask

    task automatic test_specials();
        int t;
        send(2'b01, 64'hFFF0_0000_0000_0000, 4'h5, {2'b00, 80'hFFFF_8000_0000_0000_0000}, t);
        send(2'b01, 64'h7FF0_0000_0000_0001, 4'h6, {2'b10, 80'h7FFF_C000_0000_0000_0800}, t);
        send(2'b00, 64'h0000_0000_8000_0000, 4'h7, {2'b00, 80'h8000_0000_0000_0000_0000}, t);
        send(2'b01, 64'h7FF8_0000_0000_0000, 4'h8, {2'b00, 80'h7FFF_C000_0000_0000_0000}, t);
        wait_drain();
    endtask

    task automatic test_reserved();
        int t;
        send(2'b11, 64'h1234_5678_9ABC_DEF0, 4'h9, {2'b10, 80'hFFFF_C000_0000_0000_0000}, t);
        send(2'b10, 64'h0, 4'hA, {2'b10, 80'hFFFF_C000_0000_0000_0000}, t);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int t;
        logic [1:0] f;
        logic [63:0] d;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            gen(f, d);
            send(f, d, 4'(i), ref_conv(f, d), t);
            checks++;
            if (t != 1) begin
                errors++;
                $display("FAIL b2b_accept: got %0d cycles want 1", t);
            end
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        bit done = 1'b0;
        fork
            begin
                int t;
                logic [1:0] f;
                logic [63:0] d;
                for (int i = 0; i < 8; i++) begin
                    gen(f, d);
                    send(f, d, 4'(i + 8), ref_conv(f, d), t);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic test_reset_inflight();
        int t;
        out_ready = 1'b0;
        send(2'b01, 64'h4000_0000_0000_0000, 4'hB, ref_conv(2'b01, 64'h4000_0000_0000_0000), t);
        send(2'b00, 64'h0000_0000_4040_0000, 4'hC, ref_conv(2'b00, 64'h0000_0000_4040_0000), t);
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got out_valid=%b want 0", out_valid);
        end
        sb.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        drv_exp = {2'b00, 80'h3FFF_8000_0000_0000_0000};
        in_fmt = 2'b01; in_data = 64'h3FF0_0000_0000_0000; in_tag = 4'hD; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_early: got out_valid=%b want 0", out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 80'h3FFF_8000_0000_0000_0000 || out_tag !== 4'hD) begin
            errors++;
            $display("FAIL post_reset_latency: got v=%b d=%h t=%h want v=1 d=3fff8000000000000000 t=d",
                     out_valid, out_data, out_tag);
        end
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_denormals();
        test_specials();
        test_reserved();
        test_back_to_back();
        test_backpressure();
        test_reset_inflight();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
